ethernet_transmit_scheduler: RTL and testbench
==============================================

// Module: ethernet_transmit_scheduler
// PURPOSE
//  Round-robin scheduler sharing one ethernet_packet_generator among NUMBER_OF_PORTS switch egress queues.
//  Grants one requester at a time and forwards its payload bytes, registered, to the generator.
//  Enforces a maximum frame length, and an inter-frame gap counted after the generator goes idle.
//  Gates all scheduling on pll_lock.
// PARAMETERS
//  NUMBER_OF_PORTS         4     requester count, >=2
//  INTER_FRAME_GAP_CYCLES  12    idle cycles after transmit_data_valid falls, before next grant, >=1
//  MAXIMUM_FRAME_BYTES     1500  payload bytes forwarded per frame; excess bytes are discarded
//  START_TIMEOUT_CYCLES    64    cycles a grantee may take to present its first byte
// PORTS
//  clock                 in   1                    system clock
//  reset_n               in   1                    asynchronous, active-low reset
//  pll_lock              in   1                    transmit PLL locked
//  request               in   NUMBER_OF_PORTS      port i has a frame pending (level)
//  request_data          in   8*NUMBER_OF_PORTS    port i byte at [8*i+:8]
//  request_data_enable   in   NUMBER_OF_PORTS      port i byte valid
//  transmit_data_valid   in   1                    from generator: frame on wire
//  grant                 out  NUMBER_OF_PORTS      one-hot grant, registered
//  payload_data          out  8                    to generator payload_data
//  payload_data_enable   out  1                    to generator payload_data_enable
//  generator_enable      out  1                    to generator enable
//  busy                  out  1                    state != IDLE
//  frame_truncated       out  1                    1-cycle pulse: byte MAXIMUM_FRAME_BYTES+1 seen
//  frame_aborted         out  1                    1-cycle pulse: pll_lock loss or start timeout
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; round-robin pointer = NUMBER_OF_PORTS-1, so port 0 wins first.
//  - generator_enable is pll_lock registered once, in every state.
//  - IDLE: if pll_lock && |request, grant the first set request scanning pointer+1, pointer+2, ... (mod N).
//    grant goes high the next cycle; pointer updates to that port. -> START.
//  - START: wait for request_data_enable[g]. On the first byte -> STREAM.
//    START_TIMEOUT_CYCLES cycles without a byte: pulse frame_aborted, drop grant -> IDLE.
//  - STREAM: each cycle, payload_data / payload_data_enable are registered copies of port g byte/enable.
//    Latency is 1 cycle. Enable is contiguous per frame.
//    First cycle with request_data_enable[g]=0 ends the frame: drop grant -> GAP.
//    Byte counter width $clog2(MAXIMUM_FRAME_BYTES+1), cleared on each grant.
//    On arrival of byte MAXIMUM_FRAME_BYTES+1: suppress forwarding, pulse frame_truncated -> DRAIN.
//  - DRAIN: grant held, bytes discarded; enable low -> drop grant -> GAP.
//  - GAP: wait for transmit_data_valid=0, then count INTER_FRAME_GAP_CYCLES cycles -> IDLE.
//    Counter width $clog2(INTER_FRAME_GAP_CYCLES+1).
//  - pll_lock low in START/STREAM/DRAIN: force payload_data_enable=0 next cycle, pulse frame_aborted,
//    drop grant -> GAP. Lock loss in GAP/IDLE is not an abort; IDLE simply issues no grants.
//  - request[g] deasserting mid-frame is ignored; only request_data_enable[g] ends the frame.
//  - Non-granted ports' enables are ignored. grant is always one-hot or zero.
//  - payload_data is 0 whenever payload_data_enable is 0.
//  - Pointer wraps N-1 -> 0. A requester may be re-granted only after all other pending ports are served.
// TESTING
//  1. Reset, pll_lock=1, request=4'b0001, 10-byte frame 0x01..0x0A -> grant=0001;
//     payload bytes 0x01..0x0A, each 1 cycle after input; GAP; busy falls exactly 12 cycles after transmit_data_valid falls.
//  2. request=4'b1111 held, each port sends 4 bytes -> grant order 0,1,2,3,0; 12-cycle gap between each.
//  3. Port 2 sends 1502 bytes -> 1500 forwarded; frame_truncated pulses once at byte 1501;
//     grant held until enable falls.
//  4. pll_lock falls at byte 5 -> payload_data_enable=0 the next cycle, frame_aborted pulse, grant=0;
//     no new grant until pll_lock=1 and the gap completes.
//  5. Grantee never presents data -> frame_aborted after 64 cycles; next pending port granted after the gap.
//  6. reset_n asserted mid-STREAM -> all outputs 0 immediately; after release, port 0 is granted first.

Source files
------------

// File: rtl/ethernet_transmit_scheduler.sv
// Round-robin scheduler that shares one packet generator among several egress queues.
// Forwards the granted port's payload bytes with one cycle of latency, truncates oversize
// frames, enforces an inter-frame gap after the generator goes idle, and aborts on PLL loss.
module ethernet_transmit_scheduler #(
    parameter int unsigned NUMBER_OF_PORTS        = 4,
    parameter int unsigned INTER_FRAME_GAP_CYCLES = 12,
    parameter int unsigned MAXIMUM_FRAME_BYTES    = 1500,
    parameter int unsigned START_TIMEOUT_CYCLES   = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pll_lock,
    input  logic [NUMBER_OF_PORTS-1:0]   request,
    input  logic [8*NUMBER_OF_PORTS-1:0] request_data,
    input  logic [NUMBER_OF_PORTS-1:0]   request_data_enable,
    input  logic                         transmit_data_valid,
    output logic [NUMBER_OF_PORTS-1:0]   grant,
    output logic [7:0]                   payload_data,
    output logic                         payload_data_enable,
    output logic                         generator_enable,
    output logic                         busy,
    output logic                         frame_truncated,
    output logic                         frame_aborted
);

    localparam int unsigned PW = $clog2(NUMBER_OF_PORTS);
    localparam int unsigned BW = $clog2(MAXIMUM_FRAME_BYTES + 1);
    localparam int unsigned GW = $clog2(INTER_FRAME_GAP_CYCLES + 1);
    localparam int unsigned TW = $clog2(START_TIMEOUT_CYCLES + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StStream = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StGap    = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [NUMBER_OF_PORTS-1:0] grant_q, grant_d;
    logic [7:0]                 data_q, data_d;
    logic                       data_en_q, data_en_d;
    logic                       gen_en_q;
    logic                       trunc_q, trunc_d;
    logic                       abort_q, abort_d;
    logic [BW-1:0]              byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]              start_cnt_q, start_cnt_d;

    logic          found;
    logic [PW-1:0] next_ptr;
    logic [7:0]    g_data;
    logic          g_en;
    logic          lock_lost;

    // Round-robin search: first pending port after the pointer, wrapping N-1 -> 0.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] idx_p;
        found    = 1'b0;
        next_ptr = ptr_q;
        idx      = 0;
        idx_p    = '0;
        for (int unsigned i = 1; i <= NUMBER_OF_PORTS; i++) begin
            idx   = (32'(ptr_q) + i) % NUMBER_OF_PORTS;
            idx_p = PW'(idx);
            if (!found && request[idx_p]) begin
                found    = 1'b1;
                next_ptr = idx_p;
            end
        end
    end

    // The pointer always names the current grantee, so it selects that port's byte lane.
    always_comb begin
        g_data = 8'(request_data >> {ptr_q, 3'b000});
        g_en   = request_data_enable[ptr_q];
    end

    // Next-state logic; a PLL drop while a frame is owned overrides everything else.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        data_d      = 8'h00;
        data_en_d   = 1'b0;
        trunc_d     = 1'b0;
        abort_d     = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        start_cnt_d = start_cnt_q;
        lock_lost   = !pll_lock &&
                      (state_q == StStart || state_q == StStream || state_q == StDrain);

        if (lock_lost) begin
            abort_d   = 1'b1;
            grant_d   = '0;
            gap_cnt_d = '0;
            state_d   = StGap;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pll_lock && found) begin
                        grant_d           = '0;
                        grant_d[next_ptr] = 1'b1;
                        ptr_d             = next_ptr;
                        byte_cnt_d        = '0;
                        start_cnt_d       = '0;
                        state_d           = StStart;
                    end
                end
                StStart: begin
                    if (g_en) begin
                        data_d     = g_data;
                        data_en_d  = 1'b1;
                        byte_cnt_d = BW'(1);
                        state_d    = StStream;
                    end else if (start_cnt_q == TW'(START_TIMEOUT_CYCLES - 1)) begin
                        abort_d   = 1'b1;
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        start_cnt_d = start_cnt_q + 1'b1;
                    end
                end
                StStream: begin
                    if (!g_en) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else if (byte_cnt_q == BW'(MAXIMUM_FRAME_BYTES)) begin
                        // This is the first byte past the limit: stop forwarding.
                        trunc_d = 1'b1;
                        state_d = StDrain;
                    end else begin
                        data_d     = g_data;
                        data_en_d  = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!g_en) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end
                end
                StGap: begin
                    // Gap only starts counting once the generator has gone quiet.
                    if (transmit_data_valid) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == GW'(INTER_FRAME_GAP_CYCLES - 1)) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= PW'(NUMBER_OF_PORTS - 1);
            grant_q     <= '0;
            data_q      <= 8'h00;
            data_en_q   <= 1'b0;
            gen_en_q    <= 1'b0;
            trunc_q     <= 1'b0;
            abort_q     <= 1'b0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            start_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            data_en_q   <= data_en_d;
            gen_en_q    <= pll_lock;
            trunc_q     <= trunc_d;
            abort_q     <= abort_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    assign grant               = grant_q;
    assign payload_data        = data_q;
    assign payload_data_enable = data_en_q;
    assign generator_enable    = gen_en_q;
    assign busy                = (state_q != StIdle);
    assign frame_truncated     = trunc_q;
    assign frame_aborted       = abort_q;

endmodule

// File: tb/tb_ethernet_transmit_scheduler.sv
// Scoreboard bench: stimulus pushes expected bytes and grants, a monitor pops and compares.
module tb_ethernet_transmit_scheduler;

    logic        clock               = 1'b0;
    logic        reset_n             = 1'b0;
    logic        pll_lock            = 1'b0;
    logic [3:0]  request             = 4'h0;
    logic [31:0] request_data        = 32'h0;
    logic [3:0]  request_data_enable = 4'h0;
    logic        transmit_data_valid = 1'b0;
    logic [3:0]  grant;
    logic [7:0]  payload_data;
    logic        payload_data_enable;
    logic        generator_enable;
    logic        busy;
    logic        frame_truncated;
    logic        frame_aborted;

    ethernet_transmit_scheduler #(
        .NUMBER_OF_PORTS        (4),
        .INTER_FRAME_GAP_CYCLES (12),
        .MAXIMUM_FRAME_BYTES    (1500),
        .START_TIMEOUT_CYCLES   (64)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .pll_lock            (pll_lock),
        .request             (request),
        .request_data        (request_data),
        .request_data_enable (request_data_enable),
        .transmit_data_valid (transmit_data_valid),
        .grant               (grant),
        .payload_data        (payload_data),
        .payload_data_enable (payload_data_enable),
        .generator_enable    (generator_enable),
        .busy                (busy),
        .frame_truncated     (frame_truncated),
        .frame_aborted       (frame_aborted)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } byte_t;

    byte_t      exp_bytes[$];
    logic [3:0] exp_grants[$];

    int n_checks = 0;
    int n_errors = 0;
    int trunc_cnt = 0;
    int abort_cnt = 0;
    int trunc_cyc = -1;
    int abort_cyc = -1;
    int tdv_fall_cyc = -1;
    int gen_tail = 0;
    bit check_gap = 1'b0;
    logic [3:0] mon_prev_grant = 4'h0;
    logic       mon_prev_busy = 1'b0;
    logic       mon_prev_pde = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Generator model: frame on wire while bytes arrive, falls 3 cycles after the last one.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                transmit_data_valid = 1'b0;
                gen_tail = 0;
            end else if (payload_data_enable) begin
                transmit_data_valid = 1'b1;
                gen_tail = 3;
            end else if (gen_tail > 0) begin
                gen_tail--;
                if (gen_tail == 0) begin
                    transmit_data_valid = 1'b0;
                    tdv_fall_cyc = cyc;
                end
            end
        end
    end

    // Monitor: compares outputs against the scoreboard queues.
    initial begin
        byte_t e;
        forever begin
            @(negedge clock);
            if (payload_data_enable) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL payload unexpected: got 0x%0h, expected no byte (cycle %0d)",
                             payload_data, cyc);
                end else begin
                    e = exp_bytes.pop_front();
                    check("payload data", 32'(payload_data), 32'(e.data));
                    check("payload latency", cyc, e.due);
                end
            end else if (mon_prev_pde) begin
                check("payload zero when idle", 32'(payload_data), 32'h0);
            end
            if (grant !== mon_prev_grant && grant !== 4'h0) begin
                check("grant onehot", 32'($onehot(grant)), 32'h1);
                if (exp_grants.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL grant unexpected: got 0x%0h, expected no grant (cycle %0d)",
                             grant, cyc);
                end else begin
                    check("grant order", 32'(grant), 32'(exp_grants.pop_front()));
                end
            end
            if (frame_truncated) begin
                trunc_cnt++;
                trunc_cyc = cyc;
            end
            if (frame_aborted) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (mon_prev_busy && !busy && check_gap) begin
                check("gap length", cyc - tdv_fall_cyc, 12);
            end
            mon_prev_grant = grant;
            mon_prev_busy  = busy;
            mon_prev_pde   = payload_data_enable;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        request = 4'h0;
        request_data_enable = 4'h0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_grant(input int p, output int at);
        at = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (grant[p]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait grant: got no grant for port %0d, expected one within 300 cycles",
                     p);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait idle: got busy=1, expected 0 within 400 cycles");
        end
    endtask

    // Called at the negedge where the grant was seen; returns at the negedge enable drops.
    task automatic send_frame(input int p, input int n, input logic [7:0] base, input int keep);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            request_data[8*p +: 8] = base + 8'(i);
            request_data_enable[p] = 1'b1;
            if (i < keep) exp_bytes.push_back('{data: base + 8'(i), due: cyc + 1});
        end
        @(negedge clock);
        request_data_enable[p] = 1'b0;
        request_data[8*p +: 8] = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected one within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int g1;

        // Reset values.
        pll_lock = 1'b1;
        repeat (2) @(negedge clock);
        check("reset grant", 32'(grant), 32'h0);
        check("reset payload_data", 32'(payload_data), 32'h0);
        check("reset payload_enable", 32'(payload_data_enable), 32'h0);
        check("reset generator_enable", 32'(generator_enable), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset truncated", 32'(frame_truncated), 32'h0);
        check("reset aborted", 32'(frame_aborted), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check("generator_enable follows lock", 32'(generator_enable), 32'h1);

        // Single 10-byte frame on port 0.
        check_gap = 1'b1;
        exp_grants.push_back(4'b0001);
        request = 4'b0001;
        wait_grant(0, g);
        send_frame(0, 10, 8'h01, 10);
        request = 4'b0000;
        wait_idle();
        check("t1 bytes drained", exp_bytes.size(), 0);

        // All ports requesting: order 0,1,2,3,0.
        do_reset();
        exp_grants.push_back(4'b0001);
        exp_grants.push_back(4'b0010);
        exp_grants.push_back(4'b0100);
        exp_grants.push_back(4'b1000);
        exp_grants.push_back(4'b0001);
        request = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant(f % 4, g);
            send_frame(f % 4, 4, 8'(8'h10 * (f + 1)), 4);
            if (f == 4) request = 4'b0000;
        end
        wait_idle();
        check("t2 bytes drained", exp_bytes.size(), 0);
        check_gap = 1'b0;

        // Oversize frame on port 2.
        do_reset();
        exp_grants.push_back(4'b0100);
        request = 4'b0100;
        wait_grant(2, g);
        trunc_cnt = 0;
        send_frame(2, 1502, 8'h00, 1500);
        check("t3 grant held in drain", 32'(grant), 32'h4);
        request = 4'b0000;
        @(negedge clock);
        check("t3 grant dropped", 32'(grant), 32'h0);
        check("t3 truncate pulses", trunc_cnt, 1);
        check("t3 truncate cycle", trunc_cyc, g + 1501);
        wait_idle();
        check("t3 bytes drained", exp_bytes.size(), 0);

        // PLL loss at byte 5 on port 3.
        exp_grants.push_back(4'b1000);
        request = 4'b1000;
        wait_grant(3, g);
        abort_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            request_data[31:24] = 8'h40 + 8'(i);
            request_data_enable[3] = 1'b1;
            exp_bytes.push_back('{data: 8'h40 + 8'(i), due: cyc + 1});
            @(negedge clock);
        end
        request_data[31:24] = 8'h44;
        pll_lock = 1'b0;
        @(negedge clock);
        check("t4 enable off after lock loss", 32'(payload_data_enable), 32'h0);
        check("t4 abort pulse", 32'(frame_aborted), 32'h1);
        check("t4 grant dropped", 32'(grant), 32'h0);
        check("t4 generator_enable low", 32'(generator_enable), 32'h0);
        request_data_enable[3] = 1'b0;
        repeat (40) @(negedge clock);
        check("t4 no grant while unlocked", 32'(grant), 32'h0);
        check("t4 idle while unlocked", 32'(busy), 32'h0);
        exp_grants.push_back(4'b1000);
        pll_lock = 1'b1;
        wait_grant(3, g);
        send_frame(3, 2, 8'h50, 2);
        request = 4'b0000;
        wait_idle();
        check("t4 abort count", abort_cnt, 1);
        check("t4 bytes drained", exp_bytes.size(), 0);

        // Port 0 never sends: timeout, then port 1 after the gap.
        exp_grants.push_back(4'b0001);
        exp_grants.push_back(4'b0010);
        request = 4'b0011;
        wait_grant(0, g);
        abort_cnt = 0;
        wait_grant(1, g1);
        request = 4'b0000;
        check("t5 abort cycle", abort_cyc, g + 64);
        check("t5 next grant after gap", g1, abort_cyc + 13);
        check("t5 abort count", abort_cnt, 1);
        send_frame(1, 2, 8'h60, 2);
        wait_idle();

        // Reset in the middle of a frame on port 2.
        exp_grants.push_back(4'b0100);
        request = 4'b0100;
        wait_grant(2, g);
        for (int i = 0; i < 3; i++) begin
            request_data[23:16] = 8'h70 + 8'(i);
            request_data_enable[2] = 1'b1;
            exp_bytes.push_back('{data: 8'h70 + 8'(i), due: cyc + 1});
            @(negedge clock);
        end
        #2 reset_n = 1'b0;
        #1;
        check("t6 reset grant", 32'(grant), 32'h0);
        check("t6 reset payload_enable", 32'(payload_data_enable), 32'h0);
        check("t6 reset payload_data", 32'(payload_data), 32'h0);
        check("t6 reset busy", 32'(busy), 32'h0);
        check("t6 reset generator_enable", 32'(generator_enable), 32'h0);
        request_data_enable = 4'h0;
        request = 4'h0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_grants.push_back(4'b0001);
        request = 4'b1111;
        wait_grant(0, g);
        request = 4'b0000;
        send_frame(0, 1, 8'h77, 1);
        wait_idle();

        check("final bytes drained", exp_bytes.size(), 0);
        check("final grants drained", exp_grants.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
